// File: rtl/cdc_rx_sync_bank.sv
// Receive-side synchroniser bank: N_CH single-bit control channels with per-channel
// level/rise/toggle/sticky processing, plus a toggle req/ack word transfer.
module cdc_rx_sync_bank #(
    parameter int                  N_CH        = 64,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [2*N_CH-1:0]   CH_MODE     = '0,
    parameter int                  BUS_W       = 32,
    parameter int                  CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   soft_rst_i,
    input  logic [N_CH-1:0]        async_i,
    input  logic [N_CH-1:0]        sticky_clr_i,
    output logic [N_CH-1:0]        sync_o,
    input  logic                   bus_req_tgl_i,
    input  logic [BUS_W-1:0]       bus_data_i,
    output logic                   bus_ack_tgl_o,
    output logic [BUS_W-1:0]       bus_data_o,
    output logic                   bus_valid_o,
    output logic [CNT_W-1:0]       xfer_cnt_o,
    output logic                   armed_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $fatal(1, "cdc_rx_sync_bank: SYNC_STAGES must be in 2..4");
    end

    localparam int         CW          = N_CH + 1;
    localparam logic [2:0] ARM_CNT_MAX = 3'(SYNC_STAGES);

    // Bit N_CH of every chain stage carries the bus request toggle.
    (* ASYNC_REG = "TRUE" *) logic [CW-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]   hist_q;
    logic [2:0]      arm_cnt;
    logic [N_CH-1:0] s;
    logic [N_CH-1:0] h;
    logic            rq;
    logic            rh;
    logic [N_CH-1:0] sync_d;
    logic            bus_fire;

    assign {rq, s}  = sync_q[SYNC_STAGES-1];
    assign {rh, h}  = hist_q;
    assign bus_fire = armed_o & (rq ^ rh);

    // Sticky set beats clear so an edge coinciding with a clear is never lost.
    always_comb begin
        sync_d = '0;
        for (int k = 0; k < N_CH; k++) begin
            case (CH_MODE[2*k +: 2])
                2'b00:   sync_d[k] = s[k];
                2'b01:   sync_d[k] = armed_o & s[k] & ~h[k];
                2'b10:   sync_d[k] = armed_o & (s[k] ^ h[k]);
                default: sync_d[k] = (armed_o & s[k] & ~h[k]) | (sync_o[k] & ~sticky_clr_i[k]);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            hist_q        <= '0;
            sync_o        <= '0;
            bus_ack_tgl_o <= 1'b0;
            bus_data_o    <= '0;
            bus_valid_o   <= 1'b0;
            xfer_cnt_o    <= '0;
            armed_o       <= 1'b0;
            arm_cnt       <= '0;
        end else if (soft_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            hist_q        <= '0;
            sync_o        <= '0;
            bus_ack_tgl_o <= 1'b0;
            bus_data_o    <= '0;
            bus_valid_o   <= 1'b0;
            xfer_cnt_o    <= '0;
            armed_o       <= 1'b0;
            arm_cnt       <= '0;
        end else begin
            sync_q[0] <= {bus_req_tgl_i, async_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q      <= sync_q[SYNC_STAGES-1];
            sync_o      <= sync_d;
            bus_valid_o <= bus_fire;
            if (bus_fire) begin
                bus_data_o    <= bus_data_i;
                bus_ack_tgl_o <= ~bus_ack_tgl_o;
                xfer_cnt_o    <= xfer_cnt_o + 1'b1;
            end
            // Arm only after history flops hold settled values, so no edge appears at reset.
            if (!armed_o) begin
                if (arm_cnt == ARM_CNT_MAX) armed_o <= 1'b1;
                else                        arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_rx_sync_bank.sv
// Directed bench for cdc_rx_sync_bank: arming, channel modes, bus transfers and soft reset.
module tb_cdc_rx_sync_bank;

    localparam int N_CH  = 8;
    localparam int BUS_W = 32;
    localparam int CNT_W = 4;

    logic              clk;
    logic              reset_n;
    logic              soft_rst_i;
    logic [N_CH-1:0]   async_i;
    logic [N_CH-1:0]   sticky_clr_i;
    logic [N_CH-1:0]   sync_o;
    logic              bus_req_tgl_i;
    logic [BUS_W-1:0]  bus_data_i;
    logic              bus_ack_tgl_o;
    logic [BUS_W-1:0]  bus_data_o;
    logic              bus_valid_o;
    logic [CNT_W-1:0]  xfer_cnt_o;
    logic              armed_o;

    int                n_cmp = 0;
    int                n_err = 0;
    logic [BUS_W-1:0]  exp_q[$];
    logic [CNT_W-1:0]  exp_cnt = '0;

    // ch0 rise, ch1 rise, ch2 toggle, ch3 sticky, ch4 level, ch5 level, ch6 toggle, ch7 sticky
    cdc_rx_sync_bank #(
        .N_CH(N_CH), .SYNC_STAGES(2), .CH_MODE(16'hE0E5), .BUS_W(BUS_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .soft_rst_i(soft_rst_i), .async_i(async_i),
        .sticky_clr_i(sticky_clr_i), .sync_o(sync_o), .bus_req_tgl_i(bus_req_tgl_i),
        .bus_data_i(bus_data_i), .bus_ack_tgl_o(bus_ack_tgl_o), .bus_data_o(bus_data_o),
        .bus_valid_o(bus_valid_o), .xfer_cnt_o(xfer_cnt_o), .armed_o(armed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Toggle req with a held word, then wait (bounded) for the ack toggle.
    task automatic send(input logic [31:0] d);
        int  k;
        bit  seen;
        bus_data_i    = d;
        exp_q.push_back(d);
        bus_req_tgl_i = ~bus_req_tgl_i;
        k    = 0;
        seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (bus_ack_tgl_o === bus_req_tgl_i) seen = 1;
        end
        check("bus_lat", 32'(k), 32'd3);
        @(negedge clk);
        check("bus_strobe_len", 32'(bus_valid_o), 32'd0);
    endtask

    // Scoreboard: every valid strobe pops the oldest word sent.
    always @(negedge clk) begin
        if (reset_n && bus_valid_o) begin
            if (exp_q.size() == 0) begin
                check("bus_unexpected", 32'(bus_valid_o), 32'd0);
            end else begin
                logic [BUS_W-1:0] exp_d;
                exp_d   = exp_q.pop_front();
                exp_cnt = exp_cnt + 1'b1;
                check("bus_data", bus_data_o, exp_d);
                check("bus_cnt", 32'(xfer_cnt_o), 32'(exp_cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        soft_rst_i    = 1'b0;
        async_i       = 8'h01;
        sticky_clr_i  = '0;
        bus_req_tgl_i = 1'b0;
        bus_data_i    = '0;
        repeat (3) @(negedge clk);
        check("rst_sync", 32'(sync_o), 32'd0);
        check("rst_armed", 32'(armed_o), 32'd0);
        check("rst_ack", 32'(bus_ack_tgl_o), 32'd0);
        check("rst_data", bus_data_o, 32'd0);
        check("rst_valid", 32'(bus_valid_o), 32'd0);
        check("rst_cnt", 32'(xfer_cnt_o), 32'd0);

        // Arming with ch0 already high: armed after 3 edges, no pulse on ch0.
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("arm", 32'(armed_o), 32'(k >= 3));
            check("arm_sync", 32'(sync_o), 32'd0);
            if (k == 4) async_i[0] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Level latency on ch5, and a level channel ignores sticky clear.
        async_i[5] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lvl_rise", 32'(sync_o), (k >= 3) ? 32'h20 : 32'h0);
        end
        sticky_clr_i = 8'h20;
        @(negedge clk);
        sticky_clr_i = '0;
        check("gated_clr", 32'(sync_o), 32'h20);
        async_i[5] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lvl_fall", 32'(sync_o), (k >= 3) ? 32'h0 : 32'h20);
        end

        // 10-cycle pulse on ch1 (rise) and ch2 (toggle).
        async_i[2:1] = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            logic [31:0] e;
            @(negedge clk);
            e = 32'h0;
            if (k == 3)  e = 32'h06;
            if (k == 13) e = 32'h04;
            check("rise_tgl", 32'(sync_o), e);
            if (k == 10) async_i[2:1] = 2'b00;
        end

        // Sticky ch3: set, hold after input drops, clear.
        async_i[3] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("stk_set", 32'(sync_o), (k >= 3) ? 32'h08 : 32'h0);
        end
        async_i[3] = 1'b0;
        repeat (4) @(negedge clk);
        check("stk_hold", 32'(sync_o), 32'h08);
        sticky_clr_i[3] = 1'b1;
        @(negedge clk);
        sticky_clr_i = '0;
        check("stk_clr", 32'(sync_o), 32'h0);

        // Rising edge coinciding with clear: set wins.
        async_i[3] = 1'b1;
        repeat (2) @(negedge clk);
        sticky_clr_i[3] = 1'b1;
        @(negedge clk);
        sticky_clr_i = '0;
        check("stk_set_wins", 32'(sync_o), 32'h08);
        @(negedge clk);
        check("stk_after", 32'(sync_o), 32'h08);

        // Bus transfers.
        send(32'hDEADBEEF);
        check("ack_first", 32'(bus_ack_tgl_o), 32'd1);
        send(32'h12345678);
        check("ack_second", 32'(bus_ack_tgl_o), 32'd0);
        check("cnt_two", 32'(xfer_cnt_o), 32'd2);
        for (int i = 0; i < 15; i++) send($urandom);
        check("cnt_wrap17", 32'(xfer_cnt_o), 32'd1);
        for (int i = 0; i < 4; i++) send($urandom_range(32'hFFFF, 0));
        check("cnt_21", 32'(xfer_cnt_o), 32'd5);
        check("stk_pre_soft", 32'(sync_o), 32'h08);

        // Soft reset with sticky set and count 5; source resyncs req to 0.
        soft_rst_i    = 1'b1;
        bus_req_tgl_i = 1'b0;
        @(negedge clk);
        soft_rst_i = 1'b0;
        exp_cnt    = '0;
        check("soft_sync", 32'(sync_o), 32'h0);
        check("soft_ack", 32'(bus_ack_tgl_o), 32'd0);
        check("soft_data", bus_data_o, 32'd0);
        check("soft_valid", 32'(bus_valid_o), 32'd0);
        check("soft_cnt", 32'(xfer_cnt_o), 32'd0);
        check("soft_armed", 32'(armed_o), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("rearm", 32'(armed_o), 32'(k >= 3));
            check("rearm_sync", 32'(sync_o), 32'h0);
        end

        send(32'hA5A50001);
        check("post_cnt", 32'(xfer_cnt_o), 32'd1);
        check("post_ack", 32'(bus_ack_tgl_o), 32'd1);
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_rx_sync_bank.md
Name: cdc_rx_sync_bank

Overview:
- Parametrised receive-side synchroniser bank for the GeMM PL control path; the generalised successor to the fixed-width two-flop control synchronisers.
- Brings N_CH asynchronous single-bit control signals into the clk domain. Each channel is configured for one of four modes: level, rising-edge pulse, toggle-to-pulse, or sticky-with-clear.
- Also transfers one BUS_W-bit word per request across the crossing, using a toggle req/ack handshake.
- Sits on the destination side of every PS/PL crossing; one instance per direction.

Parameters:
- N_CH, 64: number of single-bit channels.
- SYNC_STAGES, 2: synchroniser flop depth, legal range 2..4. Any other value is a $fatal at elaboration.
- CH_MODE, {N_CH{2'b00}}: 2 bits per channel, channel k at [2k+1:2k]. 00 level, 01 rise-pulse, 10 toggle-pulse, 11 sticky.
- BUS_W, 32: width of the handshaked data word.
- CNT_W, 16: width of the bus transfer counter.

Ports:
- clk  input  1  sole clock for this block.
- reset_n  input  1  asynchronous, active-low reset.
- soft_rst_i  input  1  synchronous, active-high, already in the clk domain. Clears the same state as reset_n.
- async_i  input  N_CH  asynchronous channel inputs.
- sticky_clr_i  input  N_CH  synchronous per-channel clear; affects mode 11 channels only.
- sync_o  output  N_CH  synchronised and mode-processed channel outputs.
- bus_req_tgl_i  input  1  asynchronous request toggle from the source domain.
- bus_data_i  input  BUS_W  source word; held stable by the source from the req toggle until it sees ack toggle.
- bus_ack_tgl_o  output  1  acknowledge toggle back to the source domain.
- bus_data_o  output  BUS_W  captured word.
- bus_valid_o  output  1  one-cycle strobe qualifying bus_data_o.
- xfer_cnt_o  output  CNT_W  count of completed bus transfers.
- armed_o  output  1  high once edge detection is enabled after reset.

Behaviour:
- Reset (reset_n low, asynchronous; or soft_rst_i high at a clk edge):
  - All flops go to 0: sync chains, history flops, sync_o, bus_ack_tgl_o, bus_data_o, bus_valid_o, xfer_cnt_o, armed_o, arm counter.
  - reset_n deassertion takes effect at the next clk edge.
  - soft_rst_i has priority over every other synchronous update in the same cycle.
- Sync chain:
  - Each async_i[k] and bus_req_tgl_i passes through SYNC_STAGES flops; the last stage is s[k].
  - A history flop h[k] <= s[k] every cycle.
  - Apply ASYNC_REG attributes to all chain flops.
- Arming:
  - After reset, a counter runs SYNC_STAGES+1 cycles, then sets armed_o = 1, which stays high until the next reset.
  - While armed_o = 0, no edge is reported in modes 01, 10 or 11, and no bus capture occurs. History flops still track, so a signal already high at reset produces no spurious event.
- Mode 00, level:
  - sync_o[k] <= s[k].
  - Latency from async_i change to sync_o is SYNC_STAGES+1 clk edges.
  - Level mode is not gated by armed_o.
- Mode 01, rise-pulse:
  - sync_o[k] <= armed & s & ~h.
  - Produces a one-cycle pulse on each 0->1 transition; 1->0 is ignored.
- Mode 10, toggle-pulse:
  - sync_o[k] <= armed & (s ^ h).
  - Produces a one-cycle pulse on every transition.
- Mode 11, sticky:
  - Set condition: armed & s & ~h. Clear condition: sticky_clr_i[k].
  - If set and clear occur in the same cycle, set wins, so no event is lost.
  - Otherwise the output holds.
- Bus handshake:
  - Let rq = synchronised bus_req_tgl_i and rh = its history flop.
  - When armed & (rq ^ rh):
    - bus_data_o <= bus_data_i.
    - bus_valid_o <= 1 for exactly one cycle.
    - bus_ack_tgl_o <= ~bus_ack_tgl_o.
    - xfer_cnt_o <= xfer_cnt_o + 1, wrapping modulo 2^CNT_W.
  - Latency from req toggle to bus_valid_o is SYNC_STAGES+1 clk edges.
  - bus_data_o holds its value until the next capture.
  - A second req toggle before ack is a protocol violation. The block still captures on each synchronised edge; it is the source's responsibility to wait.
- Reset mid-transfer: all captured state and ack are cleared. The source must re-synchronise its req to ack = 0 after its own reset.
- Gated channels: channels not in mode 11 ignore sticky_clr_i.

Test Plan:
- Arming: reset_n low 3 cycles with async_i[0] = 1 in mode 01, SYNC_STAGES = 2 -> armed_o rises 3 cycles after release; sync_o[0] never pulses.
- Level latency: mode 00 channel 5, async_i[5] 0->1 between edges -> sync_o[5] = 1 at the 3rd edge; after 1->0 it returns to 0 three edges later.
- Rise and toggle modes: a 10-cycle high pulse on ch1 (mode 01) and ch2 (mode 10) -> ch1 gives one 1-cycle pulse; ch2 gives two 1-cycle pulses 10 cycles apart.
- Sticky: mode 11 ch3 set, then sticky_clr_i[3] -> output cleared. A rising edge coinciding with sticky_clr_i[3] -> output stays 1.
- Bus: source sends 0xDEADBEEF then 0x12345678, each waiting for ack -> two bus_valid_o strobes with those values, bus_ack_tgl_o 0->1->0, xfer_cnt_o = 2. With CNT_W = 4, 17 transfers -> xfer_cnt_o = 1.
- Soft reset: soft_rst_i asserted one cycle while sticky = 1 and xfer_cnt_o = 5 -> all outputs 0 next cycle; armed_o re-arms after SYNC_STAGES+1 cycles.
